// File: rtl/id_operand_unit.sv
// Register file plus operand select for the ID/EX boundary: forwards EX/MEM/WB results and stalls on load-use.
// Operands are registered into EX with 1-cycle latency; a load-use hazard holds IF/ID for one cycle and bubbles EX.
module id_operand_unit #(
   parameter int XLEN  = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [AW-1:0]    rs1_id,
   input  logic [AW-1:0]    rs2_id,
   input  logic             rs1_used,
   input  logic             rs2_used,
   input  logic             flush_i,
   input  logic             we_ex,
   input  logic             we_mem,
   input  logic             we_wb,
   input  logic [AW-1:0]    wr_ex,
   input  logic [AW-1:0]    wr_mem,
   input  logic [AW-1:0]    wr_wb,
   input  logic [1:0]       wd_sel_ex,
   input  logic [1:0]       wd_sel_mem,
   input  logic [XLEN-1:0]  sext_ex,
   input  logic [XLEN-1:0]  alu_c_ex,
   input  logic [XLEN-1:0]  pc_ex,
   input  logic [XLEN-1:0]  sext_mem,
   input  logic [XLEN-1:0]  alu_c_mem,
   input  logic [XLEN-1:0]  pc_mem,
   input  logic [XLEN-1:0]  dram_rd_mem,
   input  logic [XLEN-1:0]  wD,
   output logic [XLEN-1:0]  rd1_ex,
   output logic [XLEN-1:0]  rd2_ex,
   output logic             valid_ex,
   output logic             stall_if_id,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] fwd_cnt
);

   typedef struct packed {
      logic            haz;
      logic            fwd;
      logic [XLEN-1:0] val;
   } opsel_t;

   logic [XLEN-1:0]  r_regs [2**AW];
   logic [XLEN-1:0]  r_rd1, r_rd2;
   logic             r_valid;
   logic [CNT_W-1:0] r_stall_cnt, r_fwd_cnt;

   logic [XLEN-1:0]  w_val_ex, w_val_mem;
   opsel_t           w_op1, w_op2;
   logic             w_hazard, w_bubble;

   always_comb begin
      case (wd_sel_ex)
         2'b00:   w_val_ex = sext_ex;
         2'b01:   w_val_ex = alu_c_ex;
         default: w_val_ex = pc_ex + XLEN'(4);
      endcase
      case (wd_sel_mem)
         2'b00:   w_val_mem = sext_mem;
         2'b01:   w_val_mem = alu_c_mem;
         2'b10:   w_val_mem = pc_mem + XLEN'(4);
         default: w_val_mem = dram_rd_mem;
      endcase
   end

   // A load still in EX has no data yet, so a match there is a hazard rather than a forward.
   function automatic opsel_t f_operand(input logic [AW-1:0] rs, input logic used);
      opsel_t o;
      o = '0;
      if (used && rs != '0) begin
         if (we_ex && wr_ex == rs) begin
            o.haz = (wd_sel_ex == 2'b11);
            o.fwd = 1'b1;
            o.val = w_val_ex;
         end else if (we_mem && wr_mem == rs) begin
            o.fwd = 1'b1;
            o.val = w_val_mem;
         end else if (we_wb && wr_wb == rs) begin
            o.fwd = 1'b1;
            o.val = wD;
         end else begin
            o.val = r_regs[rs];
         end
      end
      return o;
   endfunction

   always_comb begin
      w_op1    = f_operand(rs1_id, rs1_used);
      w_op2    = f_operand(rs2_id, rs2_used);
      w_hazard = !rst && id_valid && !flush_i && (w_op1.haz || w_op2.haz);
      w_bubble = flush_i || w_hazard || !id_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**AW; i++) r_regs[i] <= '0;
      end else if (we_wb && wr_wb != '0) begin
         r_regs[wr_wb] <= wD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd1       <= '0;
         r_rd2       <= '0;
         r_valid     <= 1'b0;
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(w_hazard);
         if (w_bubble) begin
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_valid <= 1'b0;
         end else begin
            r_rd1     <= w_op1.val;
            r_rd2     <= w_op2.val;
            r_valid   <= 1'b1;
            r_fwd_cnt <= r_fwd_cnt + CNT_W'(w_op1.fwd) + CNT_W'(w_op2.fwd);
         end
      end
   end

   assign rd1_ex      = r_rd1;
   assign rd2_ex      = r_rd2;
   assign valid_ex    = r_valid;
   assign stall_if_id = w_hazard;
   assign stall_cnt   = r_stall_cnt;
   assign fwd_cnt     = r_fwd_cnt;

endmodule

// File: tb/tb_id_operand_unit.sv
// Directed and random stimulus for id_operand_unit against a behavioural pipeline model.
module tb_id_operand_unit;

   logic        clk = 1'b0;
   logic        rst, id_valid, rs1_used, rs2_used, flush_i, we_ex, we_mem, we_wb;
   logic [4:0]  rs1_id, rs2_id, wr_ex, wr_mem, wr_wb;
   logic [1:0]  wd_sel_ex, wd_sel_mem;
   logic [31:0] sext_ex, alu_c_ex, pc_ex, sext_mem, alu_c_mem, pc_mem, dram_rd_mem, wD;
   logic [31:0] rd1_ex, rd2_ex, stall_cnt, fwd_cnt;
   logic        valid_ex, stall_if_id;

   int nchk = 0, nfail = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_rd1, m_rd2, m_stall_cnt, m_fwd_cnt;
   logic        m_valid;

   always #5 clk = ~clk;

   id_operand_unit dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .rs1_id(rs1_id), .rs2_id(rs2_id),
      .rs1_used(rs1_used), .rs2_used(rs2_used), .flush_i(flush_i),
      .we_ex(we_ex), .we_mem(we_mem), .we_wb(we_wb),
      .wr_ex(wr_ex), .wr_mem(wr_mem), .wr_wb(wr_wb),
      .wd_sel_ex(wd_sel_ex), .wd_sel_mem(wd_sel_mem),
      .sext_ex(sext_ex), .alu_c_ex(alu_c_ex), .pc_ex(pc_ex),
      .sext_mem(sext_mem), .alu_c_mem(alu_c_mem), .pc_mem(pc_mem), .dram_rd_mem(dram_rd_mem),
      .wD(wD), .rd1_ex(rd1_ex), .rd2_ex(rd2_ex), .valid_ex(valid_ex),
      .stall_if_id(stall_if_id), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Writers listed youngest first; the first one naming rs supplies the operand.
   task automatic model_operand(input logic [4:0] rs, input logic used,
                                output logic [31:0] v, output bit haz, output bit fwd);
      logic [31:0] ex_vals [4];
      logic [31:0] mem_vals [4];
      bit          en [3];
      logic [4:0]  idx [3];
      logic [31:0] val [3];
      bit          ld [3];
      bit          found;
      ex_vals  = '{sext_ex, alu_c_ex, pc_ex + 32'd4, 32'd0};
      mem_vals = '{sext_mem, alu_c_mem, pc_mem + 32'd4, dram_rd_mem};
      en  = '{we_ex, we_mem, we_wb};
      idx = '{wr_ex, wr_mem, wr_wb};
      val = '{ex_vals[wd_sel_ex], mem_vals[wd_sel_mem], wD};
      ld  = '{wd_sel_ex == 2'b11, 1'b0, 1'b0};
      v = 32'd0; haz = 0; fwd = 0; found = 0;
      if (used && rs != 0) begin
         for (int k = 0; k < 3; k++) begin
            if (!found && en[k] && idx[k] == rs) begin
               found = 1; fwd = 1; haz = ld[k]; v = val[k];
            end
         end
         if (!found) v = m_regs[rs];
      end
   endtask

   task automatic step();
      logic [31:0] v1, v2;
      bit h1, h2, f1, f2, haz, bub;
      #1;
      model_operand(rs1_id, rs1_used, v1, h1, f1);
      model_operand(rs2_id, rs2_used, v2, h2, f2);
      haz = !rst && id_valid && !flush_i && (h1 || h2);
      bub = flush_i || haz || !id_valid;
      chk("stall_if_id", {31'd0, stall_if_id}, {31'd0, haz});
      @(posedge clk);
      if (rst) begin
         foreach (m_regs[i]) m_regs[i] = 32'd0;
         m_rd1 = 0; m_rd2 = 0; m_valid = 0; m_stall_cnt = 0; m_fwd_cnt = 0;
      end else begin
         if (we_wb && wr_wb != 0) m_regs[wr_wb] = wD;
         m_valid = !bub;
         m_rd1 = bub ? 32'd0 : v1;
         m_rd2 = bub ? 32'd0 : v2;
         m_stall_cnt = m_stall_cnt + 32'(haz);
         if (!bub) m_fwd_cnt = m_fwd_cnt + 32'(f1) + 32'(f2);
      end
      #1;
      chk("rd1_ex", rd1_ex, m_rd1);
      chk("rd2_ex", rd2_ex, m_rd2);
      chk("valid_ex", {31'd0, valid_ex}, {31'd0, m_valid});
      chk("stall_cnt", stall_cnt, m_stall_cnt);
      chk("fwd_cnt", fwd_cnt, m_fwd_cnt);
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 0; id_valid = 0; rs1_used = 0; rs2_used = 0; flush_i = 0;
      we_ex = 0; we_mem = 0; we_wb = 0; rs1_id = 0; rs2_id = 0;
      wr_ex = 0; wr_mem = 0; wr_wb = 0; wd_sel_ex = 0; wd_sel_mem = 0;
      sext_ex = 0; alu_c_ex = 0; pc_ex = 0; sext_mem = 0; alu_c_mem = 0;
      pc_mem = 0; dram_rd_mem = 0; wD = 0;
   endtask

   task automatic load_use_setup();
      idle();
      id_valid = 1; rs2_id = 9; rs2_used = 1;
      we_ex = 1; wr_ex = 9; wd_sel_ex = 2'b11;
   endtask

   initial begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_rd1 = 0; m_rd2 = 0; m_valid = 0; m_stall_cnt = 0; m_fwd_cnt = 0;
      idle();
      @(negedge clk);

      // Reset while a load-use pattern is present: no stall is reported.
      load_use_setup(); rst = 1;
      step();
      chk("reset_rd1", rd1_ex, 32'd0);
      chk("reset_valid", {31'd0, valid_ex}, 32'd0);

      idle(); we_wb = 1; wr_wb = 5; wD = 32'hDEADBEEF;
      step();
      idle(); id_valid = 1; rs1_id = 5; rs1_used = 1;
      step();
      chk("t1_rd1", rd1_ex, 32'hDEADBEEF);
      chk("t1_valid", {31'd0, valid_ex}, 32'd1);
      chk("t1_fwd", fwd_cnt, 32'd0);

      idle(); id_valid = 1; rs2_id = 3; rs2_used = 1; we_wb = 1; wr_wb = 3; wD = 32'h11;
      step();
      chk("t2_rd2", rd2_ex, 32'h11);
      chk("t2_fwd", fwd_cnt, 32'd1);

      idle(); id_valid = 1; rs1_id = 7; rs1_used = 1;
      we_ex = 1; wr_ex = 7; wd_sel_ex = 2'b01; alu_c_ex = 32'h20;
      we_mem = 1; wr_mem = 7; wd_sel_mem = 2'b01; alu_c_mem = 32'h10;
      step();
      chk("t3_rd1", rd1_ex, 32'h20);

      load_use_setup();
      step();
      chk("t4_valid", {31'd0, valid_ex}, 32'd0);
      chk("t4_stall_cnt", stall_cnt, 32'd1);
      idle(); id_valid = 1; rs2_id = 9; rs2_used = 1;
      we_mem = 1; wr_mem = 9; wd_sel_mem = 2'b11; dram_rd_mem = 32'hCAFE;
      step();
      chk("t4_rd2", rd2_ex, 32'hCAFE);

      load_use_setup(); flush_i = 1;
      step();
      chk("t5_valid", {31'd0, valid_ex}, 32'd0);
      chk("t5_stall_cnt", stall_cnt, 32'd1);

      idle(); we_wb = 1; wr_wb = 0; wD = 32'h55;
      step();
      idle(); id_valid = 1; rs1_id = 0; rs1_used = 1; we_ex = 1; wr_ex = 0; wd_sel_ex = 2'b01;
      alu_c_ex = 32'h77;
      step();
      chk("t6_rd1", rd1_ex, 32'd0);
      chk("t6_fwd", fwd_cnt, 32'd3);

      // Reset in the middle of a stall clears everything.
      load_use_setup();
      step();
      load_use_setup(); rst = 1;
      step();
      chk("rst_mid_stall_cnt", stall_cnt, 32'd0);

      for (int n = 0; n < 1500; n++) begin
         rst        = ($urandom_range(0, 63) == 0);
         id_valid   = ($urandom_range(0, 7) != 0);
         flush_i    = ($urandom_range(0, 7) == 0);
         rs1_id     = 5'($urandom_range(0, 7));
         rs2_id     = 5'($urandom_range(0, 7));
         rs1_used   = 1'($urandom);
         rs2_used   = 1'($urandom);
         we_ex      = 1'($urandom);
         we_mem     = 1'($urandom);
         we_wb      = 1'($urandom);
         wr_ex      = 5'($urandom_range(0, 7));
         wr_mem     = 5'($urandom_range(0, 7));
         wr_wb      = 5'($urandom_range(0, 7));
         wd_sel_ex  = 2'($urandom);
         wd_sel_mem = 2'($urandom);
         sext_ex    = $urandom; alu_c_ex  = $urandom; pc_ex  = $urandom;
         sext_mem   = $urandom; alu_c_mem = $urandom; pc_mem = $urandom;
         dram_rd_mem = $urandom; wD = $urandom;
         if (n % 300 == 0) pc_ex = 32'hFFFF_FFFE;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
